// File: rtl/cpu_mon_pkg.sv
// Shared types, defaults and the MISR step function for the cpu response monitor.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam int unsigned       DEF_SW   = 16;
  localparam logic [DEF_SW-1:0] DEF_POLY = 16'h1021;
  localparam int unsigned       CNT_W    = 8;

  // One MISR shift: multiply by x modulo the polynomial, then fold in the sample.
  function automatic logic [DEF_SW-1:0] misr_step(
    input logic [DEF_SW-1:0] misr,
    input logic [DEF_SW-1:0] data,
    input logic [DEF_SW-1:0] poly
  );
    return {misr[DEF_SW-2:0], 1'b0} ^ (misr[DEF_SW-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/cpu_mon_misr.sv
// Signature register: loads SEED on i_load, advances one MISR step on i_en.
module cpu_mon_misr
  import cpu_mon_pkg::*;
#(
  parameter int unsigned   SW   = DEF_SW,
  parameter logic [SW-1:0] POLY = DEF_POLY,
  parameter logic [SW-1:0] SEED = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [SW-1:0] i_data,
  output logic [SW-1:0] o_misr,
  output logic [SW-1:0] o_misr_nxt
);

  logic [SW-1:0] r_misr;
  logic [SW-1:0] w_misr_nxt;

  generate
    if (SW == DEF_SW) begin : g_pkg_step
      assign w_misr_nxt = misr_step(r_misr, i_data, POLY);
    end else begin : g_generic_step
      assign w_misr_nxt = {r_misr[SW-2:0], 1'b0} ^ (r_misr[SW-1] ? POLY : '0) ^ i_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misr <= SEED;
    end else if (i_load) begin
      r_misr <= SEED;
    end else if (i_en) begin
      r_misr <= w_misr_nxt;
    end
  end

  assign o_misr     = r_misr;
  assign o_misr_nxt = w_misr_nxt;

endmodule

// File: rtl/cpu_resp_monitor.sv
// Response monitor: windows dut_out into a MISR signature, checks it, tracks toggle coverage.
// Toggle coverage is built only when CPU_MON_TOGGLE_COV_EN is defined.
module cpu_resp_monitor
  import cpu_mon_pkg::*;
#(
  parameter int unsigned   DW      = 8,
  parameter int unsigned   SW      = DEF_SW,
  parameter logic [SW-1:0] POLY    = DEF_POLY,
  parameter logic [SW-1:0] SEED    = '0,
  parameter int unsigned   SAMPLES = 20,
  parameter logic [SW-1:0] EXP_SIG = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    dut_out,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SW-1:0]    signature,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [DW-1:0]    tog_rise,
  output logic [DW-1:0]    tog_fall,
  output logic             cov_full,
  output mon_state_e       o_dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic             w_load;
  logic             w_sample;
  logic             w_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic [SW-1:0]    w_misr;
  logic [SW-1:0]    w_misr_nxt;

  // start/abort are level controls sampled each edge: start is honoured in IDLE or
  // DONE, abort only in RUN where it beats both start and that cycle's sample.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_last      = (r_cnt == LAST_CNT);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_sample = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || w_load) begin
      r_cnt <= '0;
    end else if (w_sample && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Verdict is captured from the final sample's next-signature, so it is valid on DONE entry.
  always_ff @(posedge clk) begin
    if (reset || w_load) begin
      r_pass <= 1'b0;
    end else if (w_sample && w_last) begin
      r_pass <= (w_misr_nxt == EXP_SIG);
    end
  end

  cpu_mon_misr #(
    .SW   (SW),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_en       (w_sample),
    .i_data     (SW'(dut_out)),
    .o_misr     (w_misr),
    .o_misr_nxt (w_misr_nxt)
  );

`ifdef CPU_MON_TOGGLE_COV_EN
  logic [DW-1:0] r_prev;
  logic          r_prev_valid;
  logic [DW-1:0] r_rise;
  logic [DW-1:0] r_fall;

  // Sticky bits survive window restarts; only the first sample of a window is a reference.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rise       <= '0;
      r_fall       <= '0;
    end else if (w_load) begin
      r_prev_valid <= 1'b0;
    end else if (w_sample) begin
      r_prev       <= dut_out;
      r_prev_valid <= 1'b1;
      if (r_prev_valid) begin
        r_rise <= r_rise | (~r_prev & dut_out);
        r_fall <= r_fall | (r_prev & ~dut_out);
      end
    end
  end

  assign tog_rise = r_rise;
  assign tog_fall = r_fall;
  assign cov_full = (&r_rise) & (&r_fall);
`else
  assign tog_rise = '0;
  assign tog_fall = '0;
  assign cov_full = 1'b0;
`endif

  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign pass        = r_pass;
  assign signature   = w_misr;
  assign sample_cnt  = r_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: doc/cpu_resp_monitor.md
# cpu_resp_monitor

Synthesizable response monitor on the `cpu` output bus. It samples `out[7:0]` over a programmable window and compacts the samples into a 16-bit MISR signature. It compares the signature against an expected value and tracks per-bit toggle coverage. It is the consuming end of the cpu stimulus/response path, used for on-chip self-test and as a bench checker.

## Interface
Parameters:
- `DW`, 8, monitored bus width
- `SW`, 16, signature width
- `POLY`, 16'h1021, MISR feedback polynomial
- `SEED`, 16'h0000, MISR value loaded on start
- `SAMPLES`, 20, samples per window (≥1)
- `EXP_SIG`, 16'h0000, expected signature

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `dut_out`  in  DW  cpu `out` bus
- `start`  in  1  begin a window (IDLE or DONE)
- `abort`  in  1  cancel a window in progress
- `busy`  out  1  window in progress
- `done`  out  1  window complete, held until next start/reset
- `pass`  out  1  valid while `done`: signature == EXP_SIG
- `signature`  out  SW  current MISR value
- `sample_cnt`  out  8  samples taken in current window
- `tog_rise`  out  DW  sticky: bit seen 0→1
- `tog_fall`  out  DW  sticky: bit seen 1→0
- `cov_full`  out  1  &tog_rise & &tog_fall

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`: MISR←SEED, cnt←0, prev_valid←0, → RUN.
  - `abort` ignored.
- RUN, every cycle:
  - MISR ← {MISR[SW-2:0],1'b0} ^ (MISR[SW-1] ? POLY : 0) ^ zero-extended `dut_out`.
  - cnt++.
  - On the SAMPLES-th sample → DONE.
- RUN + `abort` (priority over sampling): → IDLE. No sample that cycle, `done` stays 0, MISR/cnt frozen.
- RUN + `start`: ignored.
- DONE:
  - `done`=1; `pass` registered on entry.
  - `start` clears `done`/`pass` and re-enters RUN with the seed reloaded.
- Toggle tracking, per bit in RUN:
  - `prev` holds the last sample.
  - First sample of each window only loads `prev` (prev_valid←1).
  - After that, a rise/fall sets the sticky bit. Sticky bits persist across windows and clear only on `reset`.
- `sample_cnt` saturates at 255. SAMPLES>255 is illegal.
- Reset values: `busy`/`done`/`pass`/`cov_full`=0, `signature`=SEED, `sample_cnt`=0, `tog_rise`/`tog_fall`=0, state IDLE.
- Reset mid-window: everything returns to reset values the next edge. No `done`.

## Timing
- `start` sampled at edge N → `busy`=1 after N. First sample of `dut_out` is taken at edge N+1.
- The last sample is at edge N+SAMPLES. `done`/`pass` are valid after that edge, with `busy`=0.
- `signature` and `sample_cnt` update the same edge as each sample, no extra latency.
- `cov_full` is combinational from the sticky registers.
- `start` and `abort` both high in RUN: abort wins. In IDLE: start wins.

## Configuration
- `CPU_MON_TOGGLE_COV_EN` defined:
  - toggle registers, `prev`, and `cov_full` are built as above.
- Undefined:
  - `tog_rise`/`tog_fall` tied 0, `cov_full` tied 0, no `prev` register.
  - Signature/FSM behaviour is unchanged.

## Structure
- Package `cpu_mon_pkg`:
  - state enum (IDLE/RUN/DONE)
  - default `POLY`, `SW`
  - function `misr_step(misr, data, poly)`
- One sub-module, `cpu_mon_misr`: the MISR register with load/enable. The FSM, counter and toggle logic live in the top.

## Test plan
- SEED=0, SAMPLES=1, `dut_out`=8'h6F, pulse `start` → `done` one edge after first sample, `signature`=16'h006F, `sample_cnt`=1.
- SEED=0, SAMPLES=2, samples 8'h6F then 8'h00 → `signature`=16'h00DE. With EXP_SIG=16'h00DE, `pass`=1; with EXP_SIG=0, `pass`=0.
- SEED=16'h8000, SAMPLES=1, `dut_out`=0 → `signature`=16'h1021 (feedback path).
- SAMPLES=20: `abort` at sample 5 → IDLE, `done`=0, `sample_cnt`=5. Restart → full 20 samples, `done`=1.
- With the macro defined, drive 8'h00, 8'hFF, 8'h00 → `tog_rise`=8'hFF, `tog_fall`=8'hFF, `cov_full`=1. Macro undefined → all 0.
- `reset` asserted at sample 10 of 20 → next edge: state IDLE, `signature`=SEED, `done`=0, toggles cleared.
